// File: rtl/issue_scoreboard_ctrl.sv
// issue_scoreboard_ctrl: N-way in-order issue and hazard controller.
// A per-register scoreboard counts the cycles until each register's result can be forwarded.
// Each fetch group is cut at its first hazardous slot. A small FSM owns the multi-cycle
// branch-mispredict flush.
//
// Ports:
//   clk_i, reset_i         clock; synchronous active-high reset
//   slot_*_i               per-slot decode info, slot 0 oldest, fields packed k*RA_W +: RA_W
//   mispredict_i           branch in E resolved wrong this cycle
//   issue_mask_o           lanes issuing this cycle (always a prefix of ones)
//   issue_count_o          popcount of issue_mask_o; fetch advances by this
//   stall_f_o              slot 0 valid but nothing issues
//   flush_d_o, flush_e_o   squash decode / execute stage groups
//   flushing_o             FSM in the flush state
module issue_scoreboard_ctrl #(
    parameter int unsigned ISSUE_W   = 2,
    parameter int unsigned NREG      = 32,
    parameter int unsigned RA_W      = 5,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned LOAD_LAT  = 2,
    parameter int unsigned ALU_LAT   = 0,
    parameter int unsigned MEM_PORTS = 1,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [ISSUE_W-1:0]              slot_valid_i,
    input  logic [ISSUE_W*RA_W-1:0]         slot_rs_i,
    input  logic [ISSUE_W*RA_W-1:0]         slot_rt_i,
    input  logic [ISSUE_W-1:0]              slot_rs_used_i,
    input  logic [ISSUE_W-1:0]              slot_rt_used_i,
    input  logic [ISSUE_W-1:0]              slot_wr_en_i,
    input  logic [ISSUE_W*RA_W-1:0]         slot_wr_reg_i,
    input  logic [ISSUE_W-1:0]              slot_is_load_i,
    input  logic [ISSUE_W-1:0]              slot_is_mem_i,
    input  logic [ISSUE_W-1:0]              slot_is_ctrl_i,
    input  logic                            mispredict_i,
    output logic [ISSUE_W-1:0]              issue_mask_o,
    output logic [$clog2(ISSUE_W+1)-1:0]    issue_count_o,
    output logic                            stall_f_o,
    output logic                            flush_d_o,
    output logic                            flush_e_o,
    output logic                            flushing_o
);

    localparam int unsigned CW         = $clog2(ISSUE_W + 1);
    localparam int unsigned FC_W       = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC - 1) : 1;
    localparam int unsigned FLUSH_LOAD = (FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0;

    if (LOAD_LAT > 2 ** CNT_W - 1 || ALU_LAT > 2 ** CNT_W - 1) begin : g_lat_chk
        $error("LOAD_LAT/ALU_LAT do not fit in CNT_W bits");
    end
    if (ISSUE_W < 1 || ISSUE_W > 4 || FLUSH_CYC < 1) begin : g_param_chk
        $error("ISSUE_W must be 1..4 and FLUSH_CYC >= 1");
    end

    typedef enum logic {StRun, StFlush} state_e;

    state_e            state_q;
    logic [FC_W-1:0]   flush_cnt_q;
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic [ISSUE_W-1:0] blocked;
    int unsigned       mem_cnt;
    logic              run_ok;
    logic              prefix_ok;

    // Per-slot hazard detection against the scoreboard and against older slots in the group.
    always_comb begin
        blocked = '0;
        mem_cnt = 0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (!slot_valid_i[k]) blocked[k] = 1'b1;
            if (slot_rs_used_i[k] && slot_rs_i[k*RA_W +: RA_W] != '0 &&
                cnt_q[slot_rs_i[k*RA_W +: RA_W]] != '0) blocked[k] = 1'b1;
            if (slot_rt_used_i[k] && slot_rt_i[k*RA_W +: RA_W] != '0 &&
                cnt_q[slot_rt_i[k*RA_W +: RA_W]] != '0) blocked[k] = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (slot_wr_en_i[j] && slot_wr_reg_i[j*RA_W +: RA_W] != '0) begin
                    if (slot_rs_used_i[k] &&
                        slot_rs_i[k*RA_W +: RA_W] == slot_wr_reg_i[j*RA_W +: RA_W])
                        blocked[k] = 1'b1;
                    if (slot_rt_used_i[k] &&
                        slot_rt_i[k*RA_W +: RA_W] == slot_wr_reg_i[j*RA_W +: RA_W])
                        blocked[k] = 1'b1;
                    if (slot_wr_en_i[k] &&
                        slot_wr_reg_i[k*RA_W +: RA_W] == slot_wr_reg_i[j*RA_W +: RA_W])
                        blocked[k] = 1'b1;
                end
                if (slot_is_ctrl_i[j]) blocked[k] = 1'b1;
            end
            if (slot_is_mem_i[k]) mem_cnt = mem_cnt + 1;
            if (mem_cnt > MEM_PORTS) blocked[k] = 1'b1;
        end
    end

    // Mispredict in RUN takes priority over issue; nothing issues while flushing.
    assign run_ok = !reset_i && state_q == StRun && !mispredict_i;

    always_comb begin
        issue_mask_o = '0;
        prefix_ok    = 1'b1;
        for (int k = 0; k < ISSUE_W; k++) begin
            prefix_ok       = prefix_ok && !blocked[k];
            issue_mask_o[k] = run_ok && prefix_ok;
        end
    end

    always_comb begin
        issue_count_o = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            issue_count_o = issue_count_o + CW'(issue_mask_o[k]);
        end
    end

    assign stall_f_o  = !reset_i && slot_valid_i[0] && issue_count_o == '0;
    assign flush_e_o  = !reset_i && state_q == StRun && mispredict_i;
    assign flushing_o = !reset_i && state_q == StFlush;
    assign flush_d_o  = flush_e_o || flushing_o;

    // Decrement every live counter; a fresh issue overrides the decrement for its target.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            if (issue_mask_o[k] && slot_wr_en_i[k] && slot_wr_reg_i[k*RA_W +: RA_W] != '0) begin
                cnt_d[slot_wr_reg_i[k*RA_W +: RA_W]] =
                    slot_is_load_i[k] ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                StRun: begin
                    if (mispredict_i && FLUSH_CYC > 1) begin
                        state_q     <= StFlush;
                        flush_cnt_q <= FC_W'(FLUSH_LOAD);
                    end
                end
                StFlush: begin
                    // Further mispredicts are wrong-path and already squashed.
                    if (flush_cnt_q == '0) state_q <= StRun;
                    else flush_cnt_q <= flush_cnt_q - 1'b1;
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
module tb_issue_scoreboard_ctrl;

    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] slot_valid, slot_rs_used, slot_rt_used, slot_wr_en;
    logic [IW-1:0] slot_is_load, slot_is_mem, slot_is_ctrl;
    logic [IW*5-1:0] slot_rs, slot_rt, slot_wr_reg;
    logic          mispredict;
    logic [IW-1:0] issue_mask;
    logic [2:0]    issue_count;
    logic          stall_f, flush_d, flush_e, flushing;

    int n_checks = 0;
    int n_errors = 0;

    issue_scoreboard_ctrl #(
        .ISSUE_W  (IW),
        .FLUSH_CYC(3)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .slot_valid_i  (slot_valid),
        .slot_rs_i     (slot_rs),
        .slot_rt_i     (slot_rt),
        .slot_rs_used_i(slot_rs_used),
        .slot_rt_used_i(slot_rt_used),
        .slot_wr_en_i  (slot_wr_en),
        .slot_wr_reg_i (slot_wr_reg),
        .slot_is_load_i(slot_is_load),
        .slot_is_mem_i (slot_is_mem),
        .slot_is_ctrl_i(slot_is_ctrl),
        .mispredict_i  (mispredict),
        .issue_mask_o  (issue_mask),
        .issue_count_o (issue_count),
        .stall_f_o     (stall_f),
        .flush_d_o     (flush_d),
        .flush_e_o     (flush_e),
        .flushing_o    (flushing)
    );

    always #5 clk = ~clk;

    task automatic clear_slots();
        slot_valid = '0; slot_rs_used = '0; slot_rt_used = '0; slot_wr_en = '0;
        slot_is_load = '0; slot_is_mem = '0; slot_is_ctrl = '0;
        slot_rs = '0; slot_rt = '0; slot_wr_reg = '0;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store, 3 = branch
    task automatic set_slot(input int k, input int kind, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd);
        slot_valid[k]   = 1'b1;
        slot_rs[k*5 +: 5] = rs;
        slot_rt[k*5 +: 5] = rt;
        slot_rs_used[k] = 1'b1;
        slot_rt_used[k] = (kind != 1);
        slot_wr_en[k]   = (kind <= 1);
        slot_wr_reg[k*5 +: 5] = rd;
        slot_is_load[k] = (kind == 1);
        slot_is_mem[k]  = (kind == 1 || kind == 2);
        slot_is_ctrl[k] = (kind == 3);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_issue(input string tag, input logic [3:0] m, input logic [2:0] c,
                               input logic s);
        check({tag, ".mask"}, 32'(issue_mask), 32'(m));
        check({tag, ".count"}, 32'(issue_count), 32'(c));
        check({tag, ".stall"}, 32'(stall_f), 32'(s));
    endtask

    task automatic check_flush(input string tag, input logic fd, input logic fe, input logic fl);
        check({tag, ".flush_d"}, 32'(flush_d), 32'(fd));
        check({tag, ".flush_e"}, 32'(flush_e), 32'(fe));
        check({tag, ".flushing"}, 32'(flushing), 32'(fl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mispredict = 1'b0;
        clear_slots();
        set_slot(0, 0, 5'd2, 5'd3, 5'd1);
        tick();
        #3; check_issue("reset", 4'b0000, 3'd0, 1'b0); check_flush("reset", 0, 0, 0);
        tick();
        reset = 1'b0;

        // Independent ALU pair
        clear_slots();
        set_slot(0, 0, 5'd2, 5'd3, 5'd1);
        set_slot(1, 0, 5'd3, 5'd4, 5'd2);
        #3; check_issue("alu_pair", 4'b0011, 3'd2, 1'b0); check_flush("alu_pair", 0, 0, 0);
        tick();

        // Load-use: lw r5 issues at T
        clear_slots();
        set_slot(0, 1, 5'd1, 5'd0, 5'd5);
        #3; check_issue("lw_issue", 4'b0001, 3'd1, 1'b0);
        tick();
        clear_slots();
        set_slot(0, 0, 5'd5, 5'd0, 5'd6);
        set_slot(1, 0, 5'd1, 5'd2, 5'd7);
        #3; check_issue("lu_t1", 4'b0000, 3'd0, 1'b1);
        tick();
        #3; check_issue("lu_t2", 4'b0000, 3'd0, 1'b1);
        tick();
        #3; check_issue("lu_t3", 4'b0011, 3'd2, 1'b0);
        tick();

        // Intra-group RAW, then dependent instruction alone next cycle
        clear_slots();
        set_slot(0, 0, 5'd1, 5'd2, 5'd6);
        set_slot(1, 0, 5'd6, 5'd1, 5'd7);
        #3; check_issue("raw", 4'b0001, 3'd1, 1'b0);
        tick();
        clear_slots();
        set_slot(0, 0, 5'd6, 5'd1, 5'd7);
        #3; check_issue("raw_next", 4'b0001, 3'd1, 1'b0);
        tick();

        // WAW within the group
        clear_slots();
        set_slot(0, 0, 5'd1, 5'd2, 5'd11);
        set_slot(1, 0, 5'd3, 5'd4, 5'd11);
        #3; check_issue("waw", 4'b0001, 3'd1, 1'b0);
        tick();

        // Two stores with one memory port
        clear_slots();
        set_slot(0, 2, 5'd1, 5'd2, 5'd0);
        set_slot(1, 2, 5'd3, 5'd4, 5'd0);
        #3; check_issue("two_st", 4'b0001, 3'd1, 1'b0);
        tick();

        // Branch in slot 1 ends the group
        clear_slots();
        set_slot(0, 0, 5'd1, 5'd2, 5'd8);
        set_slot(1, 3, 5'd3, 5'd4, 5'd0);
        set_slot(2, 0, 5'd3, 5'd4, 5'd9);
        set_slot(3, 0, 5'd3, 5'd4, 5'd10);
        #3; check_issue("ctrl", 4'b0011, 3'd2, 1'b0);
        tick();

        // Full four-wide issue
        clear_slots();
        for (int k = 0; k < 4; k++) set_slot(k, 0, 5'd1, 5'd2, 5'(12 + k));
        #3; check_issue("full", 4'b1111, 3'd4, 1'b0);
        tick();

        // Memory op in slot 2 after a load in slot 0
        clear_slots();
        set_slot(0, 1, 5'd1, 5'd0, 5'd16);
        set_slot(1, 0, 5'd1, 5'd2, 5'd17);
        set_slot(2, 2, 5'd3, 5'd4, 5'd0);
        set_slot(3, 0, 5'd1, 5'd2, 5'd18);
        #3; check_issue("mem_cut", 4'b0011, 3'd2, 1'b0);
        tick();

        // Mispredict with three flush cycles; second mispredict while flushing is ignored
        clear_slots();
        set_slot(0, 0, 5'd2, 5'd3, 5'd1);
        mispredict = 1'b1;
        #3; check_issue("mp_t0", 4'b0000, 3'd0, 1'b1); check_flush("mp_t0", 1, 1, 0);
        tick();
        #3; check_issue("mp_t1", 4'b0000, 3'd0, 1'b1); check_flush("mp_t1", 1, 0, 1);
        tick();
        mispredict = 1'b0;
        #3; check_issue("mp_t2", 4'b0000, 3'd0, 1'b1); check_flush("mp_t2", 1, 0, 1);
        tick();
        #3; check_issue("mp_t3", 4'b0001, 3'd1, 1'b0); check_flush("mp_t3", 0, 0, 0);
        tick();

        // Reset in the middle of a flush
        mispredict = 1'b1;
        #3; check_flush("mr_t0", 1, 1, 0);
        tick();
        mispredict = 1'b0;
        reset = 1'b1;
        #3; check_issue("mr_t1", 4'b0000, 3'd0, 1'b0); check_flush("mr_t1", 0, 0, 0);
        tick();
        reset = 1'b0;
        #3; check_issue("mr_t2", 4'b0001, 3'd1, 1'b0); check_flush("mr_t2", 0, 0, 0);
        tick();

        // Reset clears a live load counter
        clear_slots();
        set_slot(0, 1, 5'd1, 5'd0, 5'd20);
        #3; check_issue("lw20", 4'b0001, 3'd1, 1'b0);
        tick();
        clear_slots();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_slot(0, 0, 5'd20, 5'd0, 5'd21);
        #3; check_issue("cnt_clr", 4'b0001, 3'd1, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
